hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit five-stage CPU. Owns the enables of the PC, IF/ID and ID/EX pipeline registers. Inserts load-use stalls, flushes wrong-path instructions on EX-stage redirects (taken branch, jal, jr) and honours an external freeze. Keeps saturating stall/flush performance counters.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline sequencing states, register width, NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

   // Register-file address width.
   localparam int REGW = 4;

   // Instruction word loaded into IF/ID when it is flushed.
   localparam logic [15:0] NOP = 16'h0000;

   // Front-end sequencing states; encoding 3 is illegal.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      FLUSH   = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// 16-bit saturating event counter with enable; sticks at 16'hFFFF.
// Latency: count reflects an enabled cycle after the next clk edge.
// Backpressure: none; en is sampled every cycle.
module sat_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] count
);

   // Increment on enable unless already saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 16'h0000;
      end else if (en && (count != 16'hFFFF)) begin
         count <= count + 16'h0001;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, redirect flushes, external freeze, perf counters.
// Latency: control outputs are combinational from state and inputs, acting at the next clk edge.
// Backpressure: freeze holds PC, IF/ID and ID/EX; load-use holds PC and IF/ID while bubbling ID/EX.
module hazard_ctrl #(
   parameter int REGW     = cpu_pkg::REGW,
   parameter int LW_STALL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            freeze,
   input  logic            ifid_valid,
   input  logic [REGW-1:0] ifid_src1,
   input  logic [REGW-1:0] ifid_src2,
   input  logic            ifid_use2,
   input  logic            idex_lw,
   input  logic            idex_rf_wen,
   input  logic [REGW-1:0] idex_rdest,
   input  logic            ex_redirect,
   output logic            pc_wen,
   output logic            pc_redirect,
   output logic            ifid_wen,
   output logic            ifid_flush,
   output logic            idex_wen,
   output logic            idex_bubble,
   output logic [1:0]      state,
   output logic [15:0]     stall_count,
   output logic [15:0]     flush_count
);

   import cpu_pkg::*;

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       hz;
   logic       stall_inc;
   logic       flush_inc;

   // Load-use hazard: a load in EX writes a register the ID instruction reads; r0 never hazards.
   always_comb begin
      hz = ifid_valid & idex_lw & idex_rf_wen & (idex_rdest != '0) &
           ((idex_rdest == ifid_src1) | (ifid_use2 & (idex_rdest == ifid_src2)));
   end

   // Next-state and Mealy control outputs; priority is freeze, then redirect, then load-use.
   always_comb begin
      pc_wen      = 1'b1;
      ifid_wen    = 1'b1;
      idex_wen    = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_redirect = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      if (!rst_n) begin
         // Nothing retires while reset is asserted.
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (freeze) begin
         // EX is held too, so a pending redirect is re-presented after the freeze.
         pc_wen   = 1'b0;
         ifid_wen = 1'b0;
         idex_wen = 1'b0;
      end else if (ex_redirect) begin
         pc_redirect = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         flush_inc   = 1'b1;
         cnt_d       = 2'd0;
         state_d     = FLUSH;
      end else begin
         case (state_q)
            RUN: begin
               if (hz) begin
                  pc_wen      = 1'b0;
                  ifid_wen    = 1'b0;
                  idex_bubble = 1'b1;
                  stall_inc   = 1'b1;
                  if (LW_STALL > 1) begin
                     cnt_d   = 2'(LW_STALL - 1);
                     state_d = LDSTALL;
                  end
               end
            end
            LDSTALL: begin
               pc_wen      = 1'b0;
               ifid_wen    = 1'b0;
               idex_bubble = 1'b1;
               stall_inc   = 1'b1;
               cnt_d       = cnt_q - 2'd1;
               if (cnt_q <= 2'd1) begin
                  state_d = RUN;
               end
            end
            FLUSH: begin
               // Synchronous imem returns wrong-path data this cycle; discard it.
               ifid_flush = 1'b1;
               state_d    = RUN;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // State and remaining-bubble counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state = state_q;

   sat_counter u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (stall_inc),
      .count (stall_count)
   );

   sat_counter u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (flush_inc),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with one instance per LW_STALL setting (1 and 3).
// Latency: inputs change 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: n/a.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        freeze, ifid_valid, ifid_use2, idex_lw, idex_rf_wen, ex_redirect;
   logic [3:0]  ifid_src1, ifid_src2, idex_rdest;

   logic        pc_wen1, pc_redirect1, ifid_wen1, ifid_flush1, idex_wen1, idex_bubble1;
   logic [1:0]  state1;
   logic [15:0] stall_count1, flush_count1;
   logic        pc_wen3, pc_redirect3, ifid_wen3, ifid_flush3, idex_wen3, idex_bubble3;
   logic [1:0]  state3;
   logic [15:0] stall_count3, flush_count3;

   int checks = 0;
   int errors = 0;

   // Control vector: {pc_wen, pc_redirect, ifid_wen, ifid_flush, idex_wen, idex_bubble}
   localparam logic [5:0] C_RUN   = 6'b101010;
   localparam logic [5:0] C_RST   = 6'b101111;
   localparam logic [5:0] C_STALL = 6'b000011;
   localparam logic [5:0] C_REDIR = 6'b111111;
   localparam logic [5:0] C_FLUSH = 6'b101110;
   localparam logic [5:0] C_FRZ   = 6'b000000;

   wire [5:0] ctl1 = {pc_wen1, pc_redirect1, ifid_wen1, ifid_flush1, idex_wen1, idex_bubble1};
   wire [5:0] ctl3 = {pc_wen3, pc_redirect3, ifid_wen3, ifid_flush3, idex_wen3, idex_bubble3};

   always #5 clk = ~clk;

   hazard_ctrl #(.REGW(4), .LW_STALL(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .ifid_valid(ifid_valid),
      .ifid_src1(ifid_src1), .ifid_src2(ifid_src2), .ifid_use2(ifid_use2),
      .idex_lw(idex_lw), .idex_rf_wen(idex_rf_wen), .idex_rdest(idex_rdest),
      .ex_redirect(ex_redirect), .pc_wen(pc_wen1), .pc_redirect(pc_redirect1),
      .ifid_wen(ifid_wen1), .ifid_flush(ifid_flush1), .idex_wen(idex_wen1),
      .idex_bubble(idex_bubble1), .state(state1), .stall_count(stall_count1),
      .flush_count(flush_count1)
   );

   hazard_ctrl #(.REGW(4), .LW_STALL(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .ifid_valid(ifid_valid),
      .ifid_src1(ifid_src1), .ifid_src2(ifid_src2), .ifid_use2(ifid_use2),
      .idex_lw(idex_lw), .idex_rf_wen(idex_rf_wen), .idex_rdest(idex_rdest),
      .ex_redirect(ex_redirect), .pc_wen(pc_wen3), .pc_redirect(pc_redirect3),
      .ifid_wen(ifid_wen3), .ifid_flush(ifid_flush3), .idex_wen(idex_wen3),
      .idex_bubble(idex_bubble3), .state(state3), .stall_count(stall_count3),
      .flush_count(flush_count3)
   );

   task automatic clear_inputs();
      freeze = 0; ifid_valid = 0; ifid_use2 = 0; idex_lw = 0; idex_rf_wen = 0;
      ex_redirect = 0; ifid_src1 = 0; ifid_src2 = 0; idex_rdest = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      nxt();
      rst_n = 1;
   endtask

   // Load with rdest 3 in EX, ID reads r3 as src1.
   task automatic set_hz_src1();
      ifid_valid = 1; idex_lw = 1; idex_rf_wen = 1; idex_rdest = 4'd3; ifid_src1 = 4'd3;
      ifid_use2 = 0; ifid_src2 = 4'd7;
   endtask

   // Load with rdest 5 in EX, ID reads r5 as src2.
   task automatic set_hz_src2();
      ifid_valid = 1; idex_lw = 1; idex_rf_wen = 1; idex_rdest = 4'd5; ifid_src1 = 4'd2;
      ifid_use2 = 1; ifid_src2 = 4'd5;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      @(negedge clk);
      checks++; if (ctl1 !== C_RST) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl1, C_RST); end
      checks++; if (state1 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state1); end
      checks++; if (stall_count1 !== 16'd0 || flush_count1 !== 16'd0) begin errors++; $display("FAIL reset_counts got %h/%h exp 0/0", stall_count1, flush_count1); end
      nxt();
      rst_n = 1;
      @(negedge clk);
      checks++; if (ctl3 !== C_RUN) begin errors++; $display("FAIL reset_release_ctl got %b exp %b", ctl3, C_RUN); end
      nxt();
   endtask

   task automatic test_load_use();
      do_reset();
      set_hz_src1();
      @(negedge clk);
      checks++; if (ctl1 !== C_STALL) begin errors++; $display("FAIL lu_bubble_ctl got %b exp %b", ctl1, C_STALL); end
      nxt();
      idex_lw = 0; idex_rf_wen = 0;  // EX now holds the bubble
      @(negedge clk);
      checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL lu_after_ctl got %b exp %b", ctl1, C_RUN); end
      checks++; if (state1 !== 2'd0) begin errors++; $display("FAIL lu_state got %0d exp 0", state1); end
      checks++; if (stall_count1 !== 16'd1) begin errors++; $display("FAIL lu_stall_count got %0d exp 1", stall_count1); end
      nxt();
   endtask

   task automatic test_multi_bubble();
      logic [1:0] exp_state [4];
      logic [5:0] exp_ctl [4];
      exp_state[0] = 2'd0; exp_state[1] = 2'd1; exp_state[2] = 2'd1; exp_state[3] = 2'd0;
      exp_ctl[0] = C_STALL; exp_ctl[1] = C_STALL; exp_ctl[2] = C_STALL; exp_ctl[3] = C_RUN;
      do_reset();
      set_hz_src2();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if (state3 !== exp_state[c]) begin errors++; $display("FAIL mb_state_c%0d got %0d exp %0d", c, state3, exp_state[c]); end
         checks++; if (ctl3 !== exp_ctl[c]) begin errors++; $display("FAIL mb_ctl_c%0d got %b exp %b", c, ctl3, exp_ctl[c]); end
         nxt();
         idex_lw = 0; idex_rf_wen = 0;
      end
      checks++; if (stall_count3 !== 16'd3) begin errors++; $display("FAIL mb_stall_count got %0d exp 3", stall_count3); end
   endtask

   task automatic test_no_false_hazard();
      do_reset();
      // r0 match
      ifid_valid = 1; idex_lw = 1; idex_rf_wen = 1; idex_rdest = 4'd0; ifid_src1 = 4'd0;
      @(negedge clk);
      checks++; if (ctl3 !== C_RUN) begin errors++; $display("FAIL nf_r0 got %b exp %b", ctl3, C_RUN); end
      nxt();
      // src2 match but src2 not read
      idex_rdest = 4'd5; ifid_src1 = 4'd1; ifid_src2 = 4'd5; ifid_use2 = 0;
      @(negedge clk);
      checks++; if (ctl3 !== C_RUN) begin errors++; $display("FAIL nf_use2 got %b exp %b", ctl3, C_RUN); end
      nxt();
      // src1 match but EX load does not write the register file
      idex_rdest = 4'd1; idex_rf_wen = 0;
      @(negedge clk);
      checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL nf_rfwen got %b exp %b", ctl1, C_RUN); end
      nxt();
      // src1 match but ID slot empty
      idex_rf_wen = 1; ifid_valid = 0;
      @(negedge clk);
      checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL nf_invalid got %b exp %b", ctl1, C_RUN); end
      nxt();
      checks++; if (stall_count1 !== 16'd0 || stall_count3 !== 16'd0) begin errors++; $display("FAIL nf_counts got %0d/%0d exp 0/0", stall_count1, stall_count3); end
   endtask

   task automatic test_redirect_in_ldstall();
      do_reset();
      set_hz_src2();
      @(negedge clk);
      nxt();
      idex_lw = 0; idex_rf_wen = 0;
      @(negedge clk);
      checks++; if (state3 !== 2'd1) begin errors++; $display("FAIL rl_enter_state got %0d exp 1", state3); end
      nxt();
      // two bubbles taken, redirect arrives in the LDSTALL cycle that follows
      ex_redirect = 1;
      @(negedge clk);
      checks++; if (ctl3 !== C_REDIR) begin errors++; $display("FAIL rl_redirect_ctl got %b exp %b", ctl3, C_REDIR); end
      nxt();
      ex_redirect = 0;
      @(negedge clk);
      checks++; if (state3 !== 2'd2 || ctl3 !== C_FLUSH) begin errors++; $display("FAIL rl_flush got state %0d ctl %b exp state 2 ctl %b", state3, ctl3, C_FLUSH); end
      nxt();
      @(negedge clk);
      checks++; if (state3 !== 2'd0 || ctl3 !== C_RUN) begin errors++; $display("FAIL rl_run got state %0d ctl %b exp state 0 ctl %b", state3, ctl3, C_RUN); end
      checks++; if (stall_count3 !== 16'd2 || flush_count3 !== 16'd1) begin errors++; $display("FAIL rl_counts got %0d/%0d exp 2/1", stall_count3, flush_count3); end
      nxt();
   endtask

   task automatic test_redirect_in_flush();
      do_reset();
      ex_redirect = 1;
      @(negedge clk);
      checks++; if (ctl1 !== C_REDIR) begin errors++; $display("FAIL rf_first got %b exp %b", ctl1, C_REDIR); end
      nxt();
      @(negedge clk);
      checks++; if (state1 !== 2'd2 || ctl1 !== C_REDIR) begin errors++; $display("FAIL rf_second got state %0d ctl %b exp state 2 ctl %b", state1, ctl1, C_REDIR); end
      nxt();
      ex_redirect = 0;
      @(negedge clk);
      checks++; if (state1 !== 2'd2 || ctl1 !== C_FLUSH) begin errors++; $display("FAIL rf_flush got state %0d ctl %b exp state 2 ctl %b", state1, ctl1, C_FLUSH); end
      checks++; if (flush_count1 !== 16'd2) begin errors++; $display("FAIL rf_flush_count got %0d exp 2", flush_count1); end
      nxt();
      @(negedge clk);
      checks++; if (state1 !== 2'd0) begin errors++; $display("FAIL rf_run got %0d exp 0", state1); end
      nxt();
   endtask

   task automatic test_freeze();
      do_reset();
      set_hz_src2();
      @(negedge clk);
      nxt();
      idex_lw = 0; idex_rf_wen = 0;
      freeze = 1; ex_redirect = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if (ctl3 !== C_FRZ) begin errors++; $display("FAIL fz_ctl_c%0d got %b exp %b", c, ctl3, C_FRZ); end
         checks++; if (state3 !== 2'd1 || stall_count3 !== 16'd1 || flush_count3 !== 16'd0) begin errors++; $display("FAIL fz_hold_c%0d got state %0d stall %0d flush %0d exp 1/1/0", c, state3, stall_count3, flush_count3); end
         nxt();
      end
      freeze = 0; ex_redirect = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (state3 !== 2'd1 || ctl3 !== C_STALL) begin errors++; $display("FAIL fz_resume_c%0d got state %0d ctl %b exp state 1 ctl %b", c, state3, ctl3, C_STALL); end
         nxt();
      end
      @(negedge clk);
      checks++; if (state3 !== 2'd0 || stall_count3 !== 16'd3) begin errors++; $display("FAIL fz_done got state %0d stall %0d exp 0/3", state3, stall_count3); end
      nxt();
   endtask

   task automatic test_saturation_and_reset();
      do_reset();
      ex_redirect = 1;
      for (int i = 0; i < 65536; i++) nxt();
      checks++; if (flush_count1 !== 16'hFFFF || flush_count3 !== 16'hFFFF) begin errors++; $display("FAIL sat_flush got %h/%h exp ffff/ffff", flush_count1, flush_count3); end
      nxt();
      ex_redirect = 0;
      nxt();
      set_hz_src2();
      nxt();
      idex_lw = 0; idex_rf_wen = 0;
      @(negedge clk);
      checks++; if (state3 !== 2'd1 || flush_count3 !== 16'hFFFF || stall_count3 !== 16'd1) begin errors++; $display("FAIL sat_ldstall got state %0d flush %h stall %0d exp 1/ffff/1", state3, flush_count3, stall_count3); end
      rst_n = 0;
      #1;
      checks++; if (state3 !== 2'd0 || stall_count3 !== 16'd0 || flush_count3 !== 16'd0 || flush_count1 !== 16'd0) begin errors++; $display("FAIL sat_reset got state %0d stall %0d flush %0d/%0d exp 0/0/0/0", state3, stall_count3, flush_count3, flush_count1); end
      checks++; if (ctl3 !== C_RST) begin errors++; $display("FAIL sat_reset_ctl got %b exp %b", ctl3, C_RST); end
      nxt();
      rst_n = 1;
      clear_inputs();
      @(negedge clk);
      checks++; if (state3 !== 2'd0 || ctl3 !== C_RUN) begin errors++; $display("FAIL sat_release got state %0d ctl %b exp state 0 ctl %b", state3, ctl3, C_RUN); end
      nxt();
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      test_reset();
      test_load_use();
      test_multi_bubble();
      test_no_false_hazard();
      test_redirect_in_ldstall();
      test_redirect_in_flush();
      test_freeze();
      test_saturation_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
